// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - operand stack with registered top-of-stack; STACK_ERR_FLAGS_EN builds sticky error flags
module stack_unit #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   input  logic                       clr_err,
   output logic [WIDTH-1:0]           tos,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    sp;
   logic [CW-1:0]    sp_m1;
   logic [CW-1:0]    sp_m2;
   logic [WIDTH-1:0] tos_q;
   logic             is_empty;
   logic             is_full;
   logic             do_push;
   logic             do_pop;
   logic             do_replace;
   logic             ovf;
   logic             unf;

   assign sp_m1    = sp - CW'(1);
   assign sp_m2    = sp - CW'(2);
   assign is_empty = (sp == '0);
   assign is_full  = (sp == CW'(DEPTH));

   // A simultaneous push+pop on an empty stack degrades to a plain push.
   assign do_replace = push && pop && !is_empty;
   assign do_push    = push && (!pop || is_empty) && !is_full;
   assign do_pop     = pop && !push && !is_empty;
   assign ovf        = push && !pop && is_full;
   assign unf        = pop && is_empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (do_push)
            mem[sp[AW-1:0]] <= din;
         else if (do_replace)
            mem[sp_m1[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp    <= '0;
         tos_q <= '0;
      end else if (do_push) begin
         sp    <= sp + CW'(1);
         tos_q <= din;
      end else if (do_replace) begin
         tos_q <= din;
      end else if (do_pop) begin
         sp    <= sp_m1;
         tos_q <= (sp >= CW'(2)) ? mem[sp_m2[AW-1:0]] : '0;
      end
   end

   assign tos   = tos_q;
   assign count = sp;
   assign empty = is_empty;
   assign full  = is_full;

`ifdef STACK_ERR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   // A new error event in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (ovf)
            overflow_q <= 1'b1;
         else if (clr_err)
            overflow_q <= 1'b0;
         if (unf)
            underflow_q <= 1'b1;
         else if (clr_err)
            underflow_q <= 1'b0;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   logic unused_err;
   assign unused_err = &{1'b0, clr_err, ovf, unf};
   assign overflow   = 1'b0;
   assign underflow  = 1'b0;
`endif

endmodule
